wb_arbiter: RTL

Shares the single register-file write port among the four execution units: ALU, LSU, MUL and DIV. Each unit pushes results into a private shallow FIFO through a valid/ready handshake. A round-robin scheduler drains one result per cycle onto the writeback port. The block sits between the execution units and the writeback stage, and replaces direct result muxing when several units finish in the same cycle.

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and constants for the writeback arbiter.
//   wb_entry_t   : {rd, data} result payload stored in each source FIFO.
//   WB_SRC_*     : source index assignment (ALU, LSU, MUL, DIV).
package wb_arbiter_pkg;

    localparam int unsigned WB_RD_W   = 5;
    localparam int unsigned WB_DATA_W = 32;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LSU = 1;
    localparam int unsigned WB_SRC_MUL = 2;
    localparam int unsigned WB_SRC_DIV = 3;

    typedef struct packed {
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result-source handshake plus register-file write port.
//   src_valid/src_rd/src_data : per-source result offer (source i at slice i)
//   src_ready                 : per-source FIFO can accept
//   wb_we/wb_rd/wb_data/wb_src: register-file write and granted source
//   idle                      : nothing buffered and nothing offered
// Modports: master = execution-unit/writeback side, slave = arbiter side.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*WB_RD_W-1:0] src_rd;
    logic [NUM_SRC*DATA_W-1:0]  src_data;
    logic [NUM_SRC-1:0]         src_ready;
    logic                       wb_we;
    logic [WB_RD_W-1:0]         wb_rd;
    logic [DATA_W-1:0]          wb_data;
    logic [SRC_W-1:0]           wb_src;
    logic                       idle;

    modport master (
        output src_valid, src_rd, src_data,
        input  src_ready, wb_we, wb_rd, wb_data, wb_src, idle
    );

    modport slave (
        input  src_valid, src_rd, src_data,
        output src_ready, wb_we, wb_rd, wb_data, wb_src, idle
    );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: shallow per-source result FIFO (DEPTH must be a power of two, >= 2).
//   push/push_entry : write at tail (caller guarantees !full)
//   pop/head        : head entry, removed on pop (caller guarantees !empty)
//   full/empty      : derived from the registered occupancy count
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Storage holds no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port among NUM_SRC execution
// units. Each source feeds a private wb_fifo; a round-robin scan starting
// after last_grant drains one head per cycle onto the wb_* port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_arbiter_if.slave (source handshake + writeback port)
// Optional feature: define WB_ARB_BYPASS_EN to let a granted source with an
// empty FIFO forward its current input straight to wb_* in the same cycle.
// Entry data is carried in wb_entry_t, so DATA_W is expected to be 32.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_entry_t          in_entry [NUM_SRC];
    wb_entry_t          heads    [NUM_SRC];
    wb_entry_t          sel;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] byp_take;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_found;

    // Per-source FIFOs and input slicing.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign in_entry[i].rd   = bus.src_rd[i*WB_RD_W +: WB_RD_W];
        assign in_entry[i].data = WB_DATA_W'(bus.src_data[i*DATA_W +: DATA_W]);

        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[i]),
            .push_entry (in_entry[i]),
            .pop        (pop[i]),
            .head       (heads[i]),
            .full       (full[i]),
            .empty      (empty[i])
        );
    end

    // Ready depends on the registered count only; a pop this cycle does not
    // free the slot until the next cycle.
    assign bus.src_ready = ~full;
    assign push          = bus.src_valid & ~full & ~byp_take;
    assign bus.idle      = (&empty) & ~(|bus.src_valid);

`ifdef WB_ARB_BYPASS_EN
    assign cand = ~empty | bus.src_valid;
`else
    assign cand = ~empty;
`endif

    // Round-robin scan: first candidate after last_grant, wrapping around.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (32'(last_grant) + k) % NUM_SRC;
            if (!gnt_found && cand[SRC_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(idx);
            end
        end
    end

    // Output mux and pop/bypass select; a buffered head always wins over new
    // input of the same source, which keeps per-source order.
    always_comb begin
        pop         = '0;
        byp_take    = '0;
        sel         = '0;
        bus.wb_we   = 1'b0;
        bus.wb_rd   = '0;
        bus.wb_data = '0;
        bus.wb_src  = '0;
        if (gnt_found) begin
`ifdef WB_ARB_BYPASS_EN
            if (empty[gnt_idx]) begin
                byp_take[gnt_idx] = 1'b1;
                sel               = in_entry[gnt_idx];
            end else begin
                pop[gnt_idx] = 1'b1;
                sel          = heads[gnt_idx];
            end
`else
            pop[gnt_idx] = 1'b1;
            sel          = heads[gnt_idx];
`endif
            // rd = 0 targets x0: consume the grant but suppress the write.
            bus.wb_we   = (sel.rd != '0);
            bus.wb_rd   = sel.rd;
            bus.wb_data = DATA_W'(sel.data);
            bus.wb_src  = gnt_idx;
        end
    end

    // Reset points at the last source so source 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else if (gnt_found) begin
            last_grant <= gnt_idx;
        end
    end

endmodule
